// File: rtl/nextkb_pkg.sv
// NeXT keyboard/mouse link, device side: shared timing defaults,
// FSM encoding, host frame patterns and response frame layout.
package nextkb_pkg;

  localparam int BIT_CLKS_D  = 265;
  localparam int HALF_CLKS_D = 132;
  localparam int RESP_GAP_D  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_START,
    S_RX_BITS,
    S_RX_RST,
    S_GAP,
    S_TX,
    S_WAIT_IDLE
  } state_t;

  // Host frames, slot 1 in the MSB
  localparam logic [6:0]  QUERY_KBD  = 7'b0000100;
  localparam logic [6:0]  QUERY_MS   = 7'b1000100;
  localparam logic [6:0]  RESET_HEAD = 7'b1111011;
  localparam logic [19:0] RESET_PAT  = 20'b11110111111000000000;

  // Response frames, slot 0 in the LSB
  localparam logic [20:0] READY_FRAME = 21'h100600;
  localparam logic [2:0]  DATA_MARK   = 3'b010;
  localparam logic        DATA_END    = 1'b0;

  function automatic logic [20:0] data_frame(input logic [15:0] d);
    return {DATA_END, d[15:8], DATA_MARK, d[7:0], 1'b0};
  endfunction

endpackage

// File: rtl/nextkb_if.sv
// Key/mouse event sources feeding the NeXT device emulator.
// master = event source, slave = device.
interface nextkb_if;
  logic        kbd_valid;
  logic [15:0] kbd_data;
  logic        kbd_ready;
  logic        ms_valid;
  logic [15:0] ms_data;
  logic        ms_ready;

  modport master (
    output kbd_valid, kbd_data, ms_valid, ms_data,
    input  kbd_ready, ms_ready
  );

  modport slave (
    input  kbd_valid, kbd_data, ms_valid, ms_data,
    output kbd_ready, ms_ready
  );
endinterface

// File: rtl/nextkb_frame_tx.sv
// 21-slot response serialiser: slot 0 first, one slot per BIT_CLKS,
// line returns high and done pulses when slot 20 ends.
module nextkb_frame_tx
  import nextkb_pkg::*;
#(
  parameter int BIT_CLKS = BIT_CLKS_D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [20:0] frame,
  output logic        busy,
  output logic        done,
  output logic        line
);

  localparam logic [15:0] BIT_M1 = 16'(BIT_CLKS - 1);

  logic [19:0] sh;
  logic [4:0]  slot;
  logic [15:0] tim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      sh   <= '0;
      slot <= '0;
      tim  <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        line <= frame[0];
        sh   <= frame[20:1];
        slot <= '0;
        tim  <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        if (tim == BIT_M1) begin
          tim <= '0;
          if (slot == 5'd20) begin
            busy <= 1'b0;
            done <= 1'b1;
            line <= 1'b1;
          end else begin
            line <= sh[0];
            sh   <= sh >> 1;
            slot <= slot + 1'b1;
          end
        end else begin
          tim <= tim + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nextkb_device.sv
// NeXT keyboard/mouse device end: decodes host frames, answers queries.
// NEXTKB_MOUSE_EN enables the mouse event buffer.
module nextkb_device
  import nextkb_pkg::*;
#(
  parameter int BIT_CLKS  = BIT_CLKS_D,
  parameter int HALF_CLKS = HALF_CLKS_D,
  parameter int RESP_GAP  = RESP_GAP_D
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     from_host,
  output logic     to_host,
  output logic     initialized,
  nextkb_if.slave  ev
);

  localparam logic [15:0] BIT_M1  = 16'(BIT_CLKS - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF_CLKS - 1);
  localparam logic [15:0] GAP_M1  =
    16'(HALF_CLKS + RESP_GAP * BIT_CLKS - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [4:0]  nbit;
  logic [19:0] rx;
  logic [19:0] rx_nxt;
  logic        fh_m, fh_s;
  logic        is_ms;
  logic        gap_end;
  logic        tx_load, tx_busy, tx_done;
  logic [20:0] tx_frame;
  logic        kbd_full, tx_kbd;
  logic [15:0] kbd_buf;
  logic        ms_full;
  logic [15:0] ms_buf;

  assign rx_nxt  = {rx[18:0], fh_s};
  assign gap_end = (state == S_GAP) && (cnt == GAP_M1);
  assign tx_load = gap_end && initialized && !tx_busy;

  always_comb begin
    tx_frame = READY_FRAME;
    unique case (1'b1)
      is_ms && ms_full:   tx_frame = data_frame(ms_buf);
      !is_ms && kbd_full: tx_frame = data_frame(kbd_buf);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fh_m        <= 1'b1;
      fh_s        <= 1'b1;
      state       <= S_IDLE;
      cnt         <= '0;
      nbit        <= '0;
      rx          <= '0;
      is_ms       <= 1'b0;
      initialized <= 1'b0;
    end else begin
      fh_m <= from_host;
      fh_s <= fh_m;
      unique case (state)
        S_IDLE: begin
          if (!fh_s) begin
            state <= S_RX_START;
            cnt   <= '0;
          end
        end
        S_RX_START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            nbit  <= '0;
            state <= fh_s ? S_IDLE : S_RX_BITS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RX_BITS, S_RX_RST: begin
          if (cnt == BIT_M1) begin
            cnt  <= '0;
            rx   <= rx_nxt;
            nbit <= nbit + 1'b1;
            if (state == S_RX_BITS && nbit == 5'd6) begin
              is_ms <= rx_nxt[6];
              if (rx_nxt[6:0] == QUERY_KBD || rx_nxt[6:0] == QUERY_MS)
                state <= S_GAP;
              else if (rx_nxt[6:0] == RESET_HEAD)
                state <= S_RX_RST;
              else
                state <= S_WAIT_IDLE;
            end else if (state == S_RX_RST && nbit == 5'd19) begin
              if (rx_nxt == RESET_PAT) initialized <= 1'b1;
              state <= S_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_M1) begin
            cnt   <= '0;
            state <= initialized ? S_TX : S_WAIT_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_TX: begin
          if (tx_done) begin
            cnt   <= '0;
            state <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (!fh_s) begin
            cnt <= '0;
          end else if (cnt == BIT_M1) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Freeing only the buffer that was actually sent keeps mid-TX events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbd_full <= 1'b0;
      kbd_buf  <= '0;
      tx_kbd   <= 1'b0;
    end else begin
      if (gap_end) tx_kbd <= initialized & ~is_ms & kbd_full;
      if (tx_done && tx_kbd) kbd_full <= 1'b0;
      if (ev.kbd_valid && !kbd_full) begin
        kbd_full <= 1'b1;
        kbd_buf  <= ev.kbd_data;
      end
    end
  end

  assign ev.kbd_ready = ~kbd_full;

`ifdef NEXTKB_MOUSE_EN
  logic tx_ms;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_full <= 1'b0;
      ms_buf  <= '0;
      tx_ms   <= 1'b0;
    end else begin
      if (gap_end) tx_ms <= initialized & is_ms & ms_full;
      if (tx_done && tx_ms) ms_full <= 1'b0;
      if (ev.ms_valid && !ms_full) begin
        ms_full <= 1'b1;
        ms_buf  <= ev.ms_data;
      end
    end
  end

  assign ev.ms_ready = ~ms_full;
`else
  logic ms_unused;

  assign ms_full     = 1'b0;
  assign ms_buf      = '0;
  assign ev.ms_ready = 1'b0;
  assign ms_unused   = ^{ev.ms_valid, ev.ms_data};
`endif

  nextkb_frame_tx #(
    .BIT_CLKS (BIT_CLKS)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tx_load),
    .frame (tx_frame),
    .busy  (tx_busy),
    .done  (tx_done),
    .line  (to_host)
  );

endmodule

// File: tb/tb_nextkb_device.sv
// Directed bench for nextkb_device acting as the host side of the link.
// Shortened bit timing; honours NEXTKB_MOUSE_EN when defined.
module tb_nextkb_device;

  localparam int B  = 120;
  localparam int H  = 60;
  localparam int RG = 3;
  // start-bit drive to response start: 3 cycles sync/detect, then
  // half slot + 7 slots to slot-7 sample, then H + RG slots of gap
  localparam int T_RESP = 3 + 2 * H + (7 + RG) * B;
  // slot 20 leftmost, slot 0 rightmost
  localparam logic [20:0] READY = 21'b1_00000000_011_00000000_0;
`ifdef NEXTKB_MOUSE_EN
  localparam logic MS_EN = 1'b1;
`else
  localparam logic MS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic from_host = 1'b1;
  logic to_host;
  logic initialized;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  nextkb_if ev ();

  nextkb_device #(
    .BIT_CLKS  (B),
    .HALF_CLKS (H),
    .RESP_GAP  (RG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .from_host   (from_host),
    .to_host     (to_host),
    .initialized (initialized),
    .ev          (ev)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic send_frame(input logic [19:0] bits, input int n,
                            output int c0);
    @(negedge clk);
    c0 = cyc;
    from_host = 1'b0;
    repeat (B) @(negedge clk);
    for (int k = n - 1; k >= 0; k--) begin
      from_host = bits[k];
      repeat (B) @(negedge clk);
    end
    from_host = 1'b1;
  endtask

  task automatic query(input logic ms, output int c0);
    send_frame({13'b0, ms, 6'b000100}, 7, c0);
  endtask

  task automatic get_resp(output logic [20:0] fr, output int t,
                          output logic rk, output logic rm,
                          output bit got);
    got = 0; fr = '0; t = 0; rk = 1'b0; rm = 1'b0;
    for (int i = 0; i < T_RESP && !got; i++) begin
      @(negedge clk);
      if (to_host === 1'b0) begin
        got = 1;
        t = cyc;
      end
    end
    if (got) begin
      for (int s = 0; s < 21; s++) begin
        repeat (s == 0 ? H : B) @(negedge clk);
        fr[s] = to_host;
        if (s == 20) begin
          rk = ev.kbd_ready;
          rm = ev.ms_ready;
        end
      end
    end
  endtask

  task automatic offer_kbd(input logic [15:0] d);
    @(negedge clk);
    ev.kbd_data = d;
    ev.kbd_valid = 1'b1;
    @(negedge clk);
    ev.kbd_valid = 1'b0;
  endtask

  task automatic test_reset;
    ev.kbd_valid = 1'b0; ev.kbd_data = '0;
    ev.ms_valid = 1'b0;  ev.ms_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (to_host !== 1'b1) begin
      errors++; $display("FAIL rst_to_host: got %b want 1", to_host);
    end
    checks++;
    if (initialized !== 1'b0) begin
      errors++; $display("FAIL rst_init: got %b want 0", initialized);
    end
    checks++;
    if (ev.kbd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_kbd_ready: got %b want 1", ev.kbd_ready);
    end
    checks++;
    if (ev.ms_ready !== MS_EN) begin
      errors++; $display("FAIL rst_ms_ready: got %b want %b", ev.ms_ready, MS_EN);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_uninit;
    int c0;
    int lows;
    lows = 0;
    query(1'b0, c0);
    for (int i = 0; i < T_RESP + 13 * B; i++) begin
      @(negedge clk);
      if (to_host !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++; $display("FAIL uninit_silent: got %0d low cycles want 0", lows);
    end
    checks++;
    if (initialized !== 1'b0) begin
      errors++; $display("FAIL uninit_flag: got %b want 0", initialized);
    end
    repeat (2 * B) @(negedge clk);
  endtask

  task automatic test_reset_frame;
    int c0, t;
    logic [20:0] fr;
    logic rk, rm;
    bit got;
    send_frame(20'b11110111111000000000, 20, c0);
    repeat (2 * B) @(negedge clk);
    checks++;
    if (initialized !== 1'b1) begin
      errors++; $display("FAIL init_flag: got %b want 1", initialized);
    end
    query(1'b0, c0);
    get_resp(fr, t, rk, rm, got);
    checks++;
    if (!got) begin
      errors++; $display("FAIL ready_timeout: got no start bit want one");
    end
    checks++;
    if (t - c0 !== T_RESP) begin
      errors++; $display("FAIL ready_latency: got %0d want %0d", t - c0, T_RESP);
    end
    checks++;
    if (fr !== READY) begin
      errors++; $display("FAIL ready_frame: got %b want %b", fr, READY);
    end
    repeat (H + 3) @(negedge clk);
    checks++;
    if (to_host !== 1'b1) begin
      errors++; $display("FAIL ready_idle: got %b want 1", to_host);
    end
    repeat (2 * B) @(negedge clk);
  endtask

  task automatic test_kbd_data;
    int c0, t;
    logic [20:0] fr;
    logic rk, rm;
    bit got;
    offer_kbd(16'h5A3C);
    checks++;
    if (ev.kbd_ready !== 1'b0) begin
      errors++; $display("FAIL kbd_taken: got %b want 0", ev.kbd_ready);
    end
    query(1'b0, c0);
    get_resp(fr, t, rk, rm, got);
    checks++;
    if (fr !== 21'b0_01011010_010_00111100_0) begin
      errors++; $display("FAIL kbd_frame: got %b want %b", fr,
                         21'b0_01011010_010_00111100_0);
    end
    checks++;
    if ({fr[19:12], fr[8:1]} !== 16'h5A3C) begin
      errors++; $display("FAIL kbd_decode: got %h want 5a3c",
                         {fr[19:12], fr[8:1]});
    end
    checks++;
    if ({fr[20], fr[11:9]} !== 4'b0010) begin
      errors++; $display("FAIL kbd_marks: got %b want 0010",
                         {fr[20], fr[11:9]});
    end
    checks++;
    if (rk !== 1'b0) begin
      errors++; $display("FAIL kbd_busy_slot20: got %b want 0", rk);
    end
    repeat (H + 3) @(negedge clk);
    checks++;
    if (ev.kbd_ready !== 1'b1) begin
      errors++; $display("FAIL kbd_freed: got %b want 1", ev.kbd_ready);
    end
    repeat (2 * B) @(negedge clk);
  endtask

  task automatic test_mouse;
    int c0, t;
    logic [20:0] fr, exp;
    logic rk, rm;
    bit got;
    @(negedge clk);
    ev.kbd_data = 16'hBEEF; ev.kbd_valid = 1'b1;
    ev.ms_data = 16'h0102;  ev.ms_valid = 1'b1;
    @(negedge clk);
    ev.kbd_valid = 1'b0; ev.ms_valid = 1'b0;
    exp = MS_EN ? 21'b0_00000001_010_00000010_0 : READY;
    query(1'b1, c0);
    get_resp(fr, t, rk, rm, got);
    checks++;
    if (fr !== exp) begin
      errors++; $display("FAIL ms_frame: got %b want %b", fr, exp);
    end
    checks++;
    if (rm !== 1'b0) begin
      errors++; $display("FAIL ms_busy_slot20: got %b want 0", rm);
    end
    checks++;
    if (rk !== 1'b0) begin
      errors++; $display("FAIL ms_kbd_kept: got %b want 0", rk);
    end
    repeat (H + 3) @(negedge clk);
    checks++;
    if (ev.ms_ready !== MS_EN) begin
      errors++; $display("FAIL ms_after: got %b want %b", ev.ms_ready, MS_EN);
    end
    repeat (2 * B) @(negedge clk);
    query(1'b0, c0);
    get_resp(fr, t, rk, rm, got);
    checks++;
    if (fr !== 21'b0_10111110_010_11101111_0) begin
      errors++; $display("FAIL ms_kbd_frame: got %b want %b", fr,
                         21'b0_10111110_010_11101111_0);
    end
    repeat (H + 3) @(negedge clk);
    checks++;
    if (ev.kbd_ready !== 1'b1) begin
      errors++; $display("FAIL ms_kbd_freed: got %b want 1", ev.kbd_ready);
    end
    repeat (2 * B) @(negedge clk);
  endtask

  task automatic test_held;
    int c0, t;
    logic [20:0] fr;
    logic rk, rm;
    bit got;
    query(1'b0, c0);
    fork
      get_resp(fr, t, rk, rm, got);
      begin
        repeat (T_RESP - 8 * B + 5 * B) @(negedge clk);
        ev.kbd_data = 16'h1234;
        ev.kbd_valid = 1'b1;
        @(negedge clk);
        ev.kbd_valid = 1'b0;
      end
    join
    checks++;
    if (fr !== READY) begin
      errors++; $display("FAIL held_ready: got %b want %b", fr, READY);
    end
    checks++;
    if (rk !== 1'b0) begin
      errors++; $display("FAIL held_taken: got %b want 0", rk);
    end
    repeat (H + 3) @(negedge clk);
    checks++;
    if (ev.kbd_ready !== 1'b0) begin
      errors++; $display("FAIL held_kept: got %b want 0", ev.kbd_ready);
    end
    repeat (2 * B) @(negedge clk);
    query(1'b0, c0);
    get_resp(fr, t, rk, rm, got);
    checks++;
    if (fr !== 21'b0_00010010_010_00110100_0) begin
      errors++; $display("FAIL held_frame: got %b want %b", fr,
                         21'b0_00010010_010_00110100_0);
    end
    repeat (H + 3) @(negedge clk);
    checks++;
    if (ev.kbd_ready !== 1'b1) begin
      errors++; $display("FAIL held_freed: got %b want 1", ev.kbd_ready);
    end
    repeat (2 * B) @(negedge clk);
  endtask

  task automatic test_glitch_rst;
    int c0, t, lows;
    bit got;
    lows = 0;
    @(negedge clk);
    from_host = 1'b0;
    repeat (50) @(negedge clk);
    from_host = 1'b1;
    for (int i = 0; i < T_RESP + 21 * B; i++) begin
      @(negedge clk);
      if (to_host !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++; $display("FAIL glitch_silent: got %0d low cycles want 0", lows);
    end
    offer_kbd(16'h0000);
    query(1'b0, c0);
    got = 0; t = 0;
    for (int i = 0; i < T_RESP && !got; i++) begin
      @(negedge clk);
      if (to_host === 1'b0) begin
        got = 1;
        t = cyc;
      end
    end
    checks++;
    if (!got || t - c0 !== T_RESP) begin
      errors++; $display("FAIL glitch_then_query: got %0d want %0d",
                         got ? t - c0 : -1, T_RESP);
    end
    repeat (10 * B + H) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (to_host !== 1'b1) begin
      errors++; $display("FAIL txrst_line: got %b want 1", to_host);
    end
    checks++;
    if (ev.kbd_ready !== 1'b1) begin
      errors++; $display("FAIL txrst_kbd_ready: got %b want 1", ev.kbd_ready);
    end
    checks++;
    if (initialized !== 1'b0) begin
      errors++; $display("FAIL txrst_init: got %b want 0", initialized);
    end
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 12 * B; i++) begin
      @(negedge clk);
      if (to_host !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++; $display("FAIL txrst_abandon: got %0d low cycles want 0", lows);
    end
  endtask

  initial begin
    test_reset();
    test_uninit();
    test_reset_frame();
    test_kbd_data();
    test_mouse();
    test_held();
    test_glitch_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
